// File: rtl/access_enable_reader_pkg.sv
// rtl/access_enable_reader_pkg.sv - shared state encoding and widths for access_enable_reader
package access_enable_reader_package;

  // Occupancy counts 0..2 buffered entries
  localparam int OCC_W = 2;

  // EMPTY: nothing buffered, ONE: main valid, TWO: main and skid valid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

endpackage

// File: rtl/access_enable_reader.sv
// rtl/access_enable_reader.sv - drains a read-enable source into a valid/ready stream via main+skid registers
module access_enable_reader
  import access_enable_reader_package::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  output logic             upstream_read_enable,
  input  logic [WIDTH-1:0] upstream_read_data,
  input  logic             upstream_empty,
  output logic             downstream_valid,
  input  logic             downstream_ready,
  output logic [WIDTH-1:0] downstream_data,
  output logic [OCC_W-1:0] occupancy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             pop;
  logic             take;

  // Pop decision uses only registered state, so downstream_ready never reaches the upstream enable;
  // held low during reset so nothing is popped into a register that is being cleared
  always_comb begin
    pop                  = !reset && !upstream_empty && (state_q != TWO);
    take                 = downstream_valid && downstream_ready;
    upstream_read_enable = pop;
    downstream_valid     = (state_q != EMPTY);
    downstream_data      = main_q;
    case (state_q)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Next-state and data steering; skid is only written when an entry arrives while main is stalled
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (pop) begin
          state_d = ONE;
          main_d  = upstream_read_data;
        end
      end
      ONE: begin
        if (pop && take) begin
          main_d = upstream_read_data;
        end else if (pop) begin
          state_d = TWO;
          skid_d  = upstream_read_data;
        end else if (take) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (take) begin
          state_d = ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State and data registers, cleared asynchronously
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_access_enable_reader.sv
// tb/tb_access_enable_reader.sv - scoreboard bench for access_enable_reader
module tb_access_enable_reader;

  localparam int WIDTH = 8;

  logic             clock;
  logic             reset;
  logic             upstream_read_enable;
  logic [WIDTH-1:0] upstream_read_data;
  logic             upstream_empty;
  logic             downstream_valid;
  logic             downstream_ready;
  logic [WIDTH-1:0] downstream_data;
  logic [1:0]       occupancy;

  access_enable_reader #(.WIDTH(WIDTH)) dut (
    .clock                (clock),
    .reset                (reset),
    .upstream_read_enable (upstream_read_enable),
    .upstream_read_data   (upstream_read_data),
    .upstream_empty       (upstream_empty),
    .downstream_valid     (downstream_valid),
    .downstream_ready     (downstream_ready),
    .downstream_data      (downstream_data),
    .occupancy            (occupancy)
  );

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] up_q[$];   // entries still held by the modelled upstream source
  logic [WIDTH-1:0] exp_q[$];  // entries popped, awaiting delivery
  int               model_occ = 0;
  int               n_pops = 0;
  int               n_takes = 0;
  int               max_occ = 0;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  // Count a comparison and report a mismatch
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present the head of the modelled source; avail=0 makes it look empty this cycle
  task automatic drive_up(input logic avail);
    upstream_empty     = !(avail && (up_q.size() > 0));
    upstream_read_data = (up_q.size() > 0) ? up_q[0] : '0;
  endtask

  // One clock cycle starting and ending at a falling edge; downstream_ready must already be set
  task automatic step(input logic avail);
    logic pop;
    logic take;
    logic [WIDTH-1:0] exp_v;
    drive_up(avail);
    #1;
    pop  = upstream_read_enable;
    take = downstream_valid && downstream_ready;
    check("no_pop_when_empty", {31'd0, pop && upstream_empty}, 32'd0);
    check("read_enable", {31'd0, pop}, {31'd0, !upstream_empty && (model_occ != 2)});
    if (take) begin
      if (exp_q.size() == 0) begin
        check("take_without_entry", 32'd1, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check("sb_data", {24'd0, downstream_data}, {24'd0, exp_v});
      end
      n_takes++;
      model_occ--;
    end
    if (pop) begin
      exp_q.push_back(up_q.pop_front());
      n_pops++;
      model_occ++;
    end
    prev_hold = downstream_valid && !downstream_ready;
    prev_data = downstream_data;
    @(posedge clock);
    @(negedge clock);
    check("occupancy", {30'd0, occupancy}, model_occ);
    if (model_occ > max_occ) max_occ = model_occ;
    if (prev_hold) begin
      check("hold_valid", {31'd0, downstream_valid}, 32'd1);
      check("hold_data", {24'd0, downstream_data}, {24'd0, prev_data});
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, {31'd0, downstream_valid}, 32'd0);
    check({tag, "_data"}, {24'd0, downstream_data}, 32'd0);
    check({tag, "_occ"}, {30'd0, occupancy}, 32'd0);
    check({tag, "_rden"}, {31'd0, upstream_read_enable}, 32'd0);
  endtask

  int pops0;
  int takes0;
  int cycles;
  logic started;

  initial begin
    reset = 1'b1;
    downstream_ready = 1'b0;
    upstream_empty = 1'b1;
    upstream_read_data = '0;
    #2;
    check_zero("reset_init");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero("after_reset_init");
    @(negedge clock);

    // Single transfer with stalled consumer
    up_q.push_back(8'hAA);
    downstream_ready = 1'b0;
    step(1'b1);
    check("single_valid", {31'd0, downstream_valid}, 32'd1);
    check("single_data", {24'd0, downstream_data}, 32'hAA);
    for (int i = 0; i < 10; i++) step(1'b1);
    check("single_held", {24'd0, downstream_data}, 32'hAA);
    downstream_ready = 1'b1;
    step(1'b1);
    check("single_drained", {31'd0, downstream_valid}, 32'd0);

    // Backpressure fill
    up_q.push_back(8'h01);
    up_q.push_back(8'h02);
    up_q.push_back(8'h03);
    downstream_ready = 1'b0;
    pops0 = n_pops;
    for (int i = 0; i < 5; i++) step(1'b1);
    check("bp_pops", n_pops - pops0, 32'd2);
    check("bp_occ", {30'd0, occupancy}, 32'd2);
    drive_up(1'b1);
    #1;
    check("bp_rden", {31'd0, upstream_read_enable}, 32'd0);
    check("bp_left", up_q.size(), 32'd1);
    @(negedge clock);
    downstream_ready = 1'b1;
    takes0 = n_takes;
    for (int i = 0; i < 3; i++) step(1'b1);
    check("bp_takes", n_takes - takes0, 32'd3);
    check("bp_empty", {31'd0, downstream_valid}, 32'd0);

    // Reset mid-operation with two entries buffered
    for (int i = 4; i < 10; i++) up_q.push_back(i[WIDTH-1:0]);
    downstream_ready = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1);
    check("pre_reset_occ", {30'd0, occupancy}, 32'd2);
    drive_up(1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_zero("reset_mid");
    up_q.delete();
    exp_q.delete();
    model_occ = 0;
    prev_hold = 1'b0;
    drive_up(1'b1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_zero("after_reset_mid");
    @(negedge clock);

    // Throughput: 100 entries with consumer always ready
    for (int i = 0; i < 100; i++) up_q.push_back(i[WIDTH-1:0]);
    downstream_ready = 1'b1;
    n_takes = 0;
    max_occ = 0;
    cycles = 0;
    started = 1'b0;
    for (int i = 0; i < 300 && n_takes < 100; i++) begin
      drive_up(1'b1);
      #1;
      if (upstream_read_enable) started = 1'b1;
      step(1'b1);
      if (started) cycles++;
    end
    check("tp_takes", n_takes, 32'd100);
    check("tp_cycles", cycles, 32'd101);
    check("tp_max_occ", max_occ, 32'd1);

    // Random availability and backpressure
    for (int i = 0; i < 100; i++) up_q.push_back(8'($urandom_range(0, 255)));
    n_takes = 0;
    for (int i = 0; i < 1000 && n_takes < 100; i++) begin
      downstream_ready = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)));
    end
    check("rand_takes", n_takes, 32'd100);
    check("rand_final_occ", {30'd0, occupancy}, 32'd0);
    check("rand_sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
